// File: rtl/nvdla_ram_fifo_pkg.sv
// Shared sizing for the RAM-backed FIFO controller and its output skid.
// DEPTH must stay a power of two so the address pointers wrap for free.
package nvdla_ram_fifo_pkg;
  localparam int DEPTH      = 128;
  localparam int AW         = 7;
  localparam int DW         = 256;
  localparam int CW         = AW + 1;
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);
endpackage

// File: rtl/nvdla_fifo_skid2.sv
// Two-entry output queue that catches RAM read data and presents it to the consumer.
// Data regs carry no reset; only pointers and count are cleared.
module nvdla_fifo_skid2
  import nvdla_ram_fifo_pkg::*;
(
  input  logic               gclk,
  input  logic               grst_n,
  input  logic               push_i,
  input  logic [DW-1:0]      push_data_i,
  input  logic               pop_i,
  output logic               valid_o,
  output logic [DW-1:0]      head_o,
  output logic [SKID_CW-1:0] cnt_o
);
  logic [SKID_DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic                          wr_ptr_q, wr_ptr_d;
  logic                          rd_ptr_q, rd_ptr_d;
  logic [SKID_CW-1:0]            cnt_q, cnt_d;
  logic                          pop;

  always_comb begin
    pop      = pop_i & (cnt_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + SKID_CW'(push_i) - SKID_CW'(pop);
  end

  always_ff @(posedge gclk) mem_q <= mem_d;

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

  // The upstream issue rule must keep a free slot for every in-flight read.
  skid_ovf_a: assert property (@(posedge gclk) disable iff (!grst_n)
    !(push_i && (cnt_q == SKID_CW'(SKID_DEPTH)) && !pop));
endmodule

// File: rtl/nvdla_ram_fifo_ctl_128x256.sv
// Sync FIFO control around an external 128x256 two-port RAM: write port from the
// producer, one-cycle read port into a 2-entry skid that feeds the consumer.
module nvdla_ram_fifo_ctl_128x256
  import nvdla_ram_fifo_pkg::*;
(
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  output logic [CW-1:0] fifo_count
);
  logic [AW-1:0]      wr_adr_q, wr_adr_d;
  logic [AW-1:0]      rd_adr_q, rd_adr_d;
  logic [CW-1:0]      ram_cnt_q, ram_cnt_d;
  logic               inflight_q, inflight_d;
  logic [SKID_CW-1:0] skid_cnt;
  logic [2:0]         occ;
  logic               push, pop, issue;

  // wr_prdy looks only at registered state: a same-cycle pop never frees a RAM slot early.
  always_comb begin
    wr_prdy    = (ram_cnt_q != CW'(DEPTH));
    push       = wr_pvld & wr_prdy;
    pop        = rd_pvld & rd_prdy;
    occ        = 3'(skid_cnt) + 3'(inflight_q);
    issue      = (ram_cnt_q != '0) && ((occ - 3'(pop)) < 3'd2);
    wr_adr_d   = wr_adr_q + AW'(push);
    rd_adr_d   = rd_adr_q + AW'(issue);
    ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(issue);
    inflight_d = issue;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wr_adr_q   <= '0;
      rd_adr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_adr_q   <= wr_adr_d;
      rd_adr_q   <= rd_adr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // ram_dout is valid the cycle after ram_re, i.e. while inflight_q is set.
  nvdla_fifo_skid2 u_skid (
    .gclk        (nvdla_core_clk),
    .grst_n      (nvdla_core_rstn),
    .push_i      (inflight_q),
    .push_data_i (ram_dout),
    .pop_i       (pop),
    .valid_o     (rd_pvld),
    .head_o      (rd_pd),
    .cnt_o       (skid_cnt)
  );

  assign ram_we     = push;
  assign ram_wa     = wr_adr_q;
  assign ram_di     = wr_pd;
  assign ram_re     = issue;
  assign ram_ra     = rd_adr_q;
  assign fifo_count = ram_cnt_q + CW'(inflight_q) + CW'(skid_cnt);

  ram_cnt_a: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    ram_cnt_q <= CW'(DEPTH));
endmodule
